tbird: RTL and testbench
========================

// Module: tbird
// PURPOSE
//   Thunderbird-style sequential tail-light controller. Three switch inputs select
//   left turn, right turn or hazard; eight lamp outputs play the outward-running
//   turn sequences or the hazard all-flash. Leaf block between the debounced
//   switch inputs and the lamp drivers.
// PARAMETERS
//   TICK_DIV  1  clock cycles per sequence step (>=1); 1 = advance every CLK edge
// PORTS
//   CLK     in   1  single clock, all state updates on rising edge
//   RST     in   1  synchronous reset, active-high
//   SW0     in   1  hazard request
//   SW1     in   1  left-turn request
//   SW2     in   1  right-turn request
//   TLIGHT  out  8  lamps: [7:4] left group (LA=[4]..LD=[7]); [3:0] right group (RA=[3]..RD=[0]); 1 = lamp on
// BEHAVIOUR
//   - Clock and reset: one clock CLK; reset RST is synchronous and active-high.
//   - On RST: state=IDLE, tick counter=0, TLIGHT=8'h00, all on the next edge. RST has priority over everything.
//   - Step enable: a counter 0..TICK_DIV-1 wraps and asserts tick at wrap. The FSM
//     advances only on tick. With TICK_DIV=1, tick=1 on every cycle.
//   - Request decode, evaluated on each tick. Priority: haz, then left, then right.
//       haz   = SW0 | (SW1 & SW2)
//       left  = SW1 & ~SW2 & ~SW0
//       right = SW2 & ~SW1 & ~SW0
//   - States: IDLE, L1..L4, R1..R4, HAZ.
//   - TLIGHT is a registered Moore output, decoded from the next state. It
//     therefore changes on the same edge as the state.
//       IDLE 00; L1 10; L2 30; L3 70; L4 F0; R1 08; R2 0C; R3 0E; R4 0F; HAZ FF (hex).
//   - Transitions on tick:
//       IDLE: haz->HAZ, left->L1, right->R1, else IDLE.
//       L1->L2->L3->L4->IDLE.
//       R1->R2->R3->R4->IDLE.
//       Any Lx or Rx with haz asserted goes to HAZ immediately, preempting the turn sequence.
//       Dropping or changing a turn request mid-sequence does not abort it: the sequence
//       completes to L4 or R4, then returns to IDLE.
//       HAZ->IDLE always. A held hazard therefore alternates FF/00 every step.
//   - Holding a turn request repeats its sequence: 00,10,30,70,F0,00,10,...
//   - No illegal-state lockup: undefined encodings go to IDLE.
// STRUCTURE
//   - Shared package tbird_pkg: state enum typedef (IDLE,L1..L4,R1..R4,HAZ) and
//     localparam lamp patterns per state.
//   - One sub-module tbird_tick_div (parameter TICK_DIV, ports CLK, RST, tick).
//   - Remaining logic is the FSM plus output register in tbird.
// TESTING
//   Defaults: TICK_DIV=1, 10 ns clock. Each line lists the TLIGHT values on successive edges.
//   1. RST=1 for 2 cycles, switches 0 -> TLIGHT=00, and it stays 00 after RST drops.
//   2. SW1=1 held -> 10,30,70,F0,00,10,...
//      Then SW1=0 while in L2 -> 70,F0,00, then holds 00.
//   3. SW2=1 held -> 08,0C,0E,0F,00,08,...
//   4. SW1=SW2=1 from IDLE -> FF,00,FF,00,... Same result for SW0=1 with any SW1/SW2.
//   5. SW1=1, then SW0=1 asserted while in L3 -> next edge FF, then 00,FF,...
//      Release all switches -> ends in 00.
//   6. RST=1 asserted while in R3 -> 00 on the next edge.
//      Also run TICK_DIV=4: each pattern is held exactly 4 cycles.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared types for the tail-light controller: sequence states and the lamp
// pattern that each state shows.
package tbird_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    L4   = 4'd4,
    R1   = 4'd5,
    R2   = 4'd6,
    R3   = 4'd7,
    R4   = 4'd8,
    HAZ  = 4'd9
  } state_t;

  // Left group lives in [7:4] and grows upward; right group in [3:0] grows downward.
  localparam logic [7:0] LAMP_IDLE = 8'h00;
  localparam logic [7:0] LAMP_L1   = 8'h10;
  localparam logic [7:0] LAMP_L2   = 8'h30;
  localparam logic [7:0] LAMP_L3   = 8'h70;
  localparam logic [7:0] LAMP_L4   = 8'hF0;
  localparam logic [7:0] LAMP_R1   = 8'h08;
  localparam logic [7:0] LAMP_R2   = 8'h0C;
  localparam logic [7:0] LAMP_R3   = 8'h0E;
  localparam logic [7:0] LAMP_R4   = 8'h0F;
  localparam logic [7:0] LAMP_HAZ  = 8'hFF;

  function automatic logic [7:0] lamps(input state_t s);
    logic [7:0] pattern;
    pattern = LAMP_IDLE;
    case (s)
      L1:      pattern = LAMP_L1;
      L2:      pattern = LAMP_L2;
      L3:      pattern = LAMP_L3;
      L4:      pattern = LAMP_L4;
      R1:      pattern = LAMP_R1;
      R2:      pattern = LAMP_R2;
      R3:      pattern = LAMP_R3;
      R4:      pattern = LAMP_R4;
      HAZ:     pattern = LAMP_HAZ;
      default: pattern = LAMP_IDLE;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/tbird_tick_div.sv
// Step-rate divider: tick is high on the cycle where the counter wraps, so the
// sequencer advances once every TICK_DIV clocks.
module tbird_tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tbird.sv
// Thunderbird tail-light sequencer: turn sequences run outward from the centre,
// hazard flashes all lamps and preempts any turn in progress.
module tbird
  import tbird_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  output logic [7:0] TLIGHT
);

  state_t state;
  state_t next;
  logic   tick;
  logic   haz;
  logic   left;
  logic   right;

  tbird_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .CLK (CLK),
    .RST (RST),
    .tick(tick)
  );

  // Both turn switches together mean the driver wants hazards, not a turn.
  assign haz   = SW0 | (SW1 & SW2);
  assign left  = SW1 & ~SW2 & ~SW0;
  assign right = SW2 & ~SW1 & ~SW0;

  always_comb begin
    next = state;
    case (state)
      IDLE: if (tick) next = haz ? HAZ : left ? L1 : right ? R1 : IDLE;
      L1:   if (tick) next = haz ? HAZ : L2;
      L2:   if (tick) next = haz ? HAZ : L3;
      L3:   if (tick) next = haz ? HAZ : L4;
      L4:   if (tick) next = haz ? HAZ : IDLE;
      R1:   if (tick) next = haz ? HAZ : R2;
      R2:   if (tick) next = haz ? HAZ : R3;
      R3:   if (tick) next = haz ? HAZ : R4;
      R4:   if (tick) next = haz ? HAZ : IDLE;
      HAZ:  if (tick) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Lamps are registered from the next state so they switch on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      TLIGHT <= LAMP_IDLE;
    end else begin
      state  <= next;
      TLIGHT <= lamps(next);
    end
  end

endmodule

// File: tb/tb_tbird.sv
// Directed bench for the tail-light sequencer at step rate 1 and 4.
module tb_tbird;

  typedef struct {
    logic       rst;
    logic [2:0] sw;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw = 3'b000;
  logic [7:0] tlight;
  logic       rst4 = 1'b1;
  logic [2:0] sw4 = 3'b000;
  logic [7:0] tlight4;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tbird #(.TICK_DIV(1)) dut (
    .CLK   (clk),
    .RST   (rst),
    .SW0   (sw[0]),
    .SW1   (sw[1]),
    .SW2   (sw[2]),
    .TLIGHT(tlight)
  );

  tbird #(.TICK_DIV(4)) dut4 (
    .CLK   (clk),
    .RST   (rst4),
    .SW0   (sw4[0]),
    .SW1   (sw4[1]),
    .SW2   (sw4[2]),
    .TLIGHT(tlight4)
  );

  task automatic addVec(input logic r, input logic [2:0] s, input logic [7:0] e, input string n);
    vec_t v;
    v.rst = r;
    v.sw = s;
    v.exp = e;
    v.name = n;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] s);
    @(negedge clk);
    rst = r;
    sw = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, want %02h", n, act, exp);
    end
  endtask

  initial begin
    logic [7:0] seq4 [6];

    // sw = {SW2, SW1, SW0}
    addVec(1, 3'b000, 8'h00, "reset0");
    addVec(1, 3'b000, 8'h00, "reset1");
    addVec(0, 3'b000, 8'h00, "idle0");
    addVec(0, 3'b000, 8'h00, "idle1");
    addVec(0, 3'b010, 8'h10, "left_l1");
    addVec(0, 3'b010, 8'h30, "left_l2");
    addVec(0, 3'b010, 8'h70, "left_l3");
    addVec(0, 3'b010, 8'hF0, "left_l4");
    addVec(0, 3'b010, 8'h00, "left_idle");
    addVec(0, 3'b010, 8'h10, "left_rep_l1");
    addVec(0, 3'b010, 8'h30, "left_rep_l2");
    addVec(0, 3'b000, 8'h70, "left_drop_l3");
    addVec(0, 3'b000, 8'hF0, "left_drop_l4");
    addVec(0, 3'b000, 8'h00, "left_drop_idle");
    addVec(0, 3'b000, 8'h00, "left_drop_hold");
    addVec(0, 3'b100, 8'h08, "right_r1");
    addVec(0, 3'b100, 8'h0C, "right_r2");
    addVec(0, 3'b100, 8'h0E, "right_r3");
    addVec(0, 3'b100, 8'h0F, "right_r4");
    addVec(0, 3'b100, 8'h00, "right_idle");
    addVec(0, 3'b100, 8'h08, "right_rep_r1");
    addVec(0, 3'b000, 8'h0C, "right_drop_r2");
    addVec(0, 3'b000, 8'h0E, "right_drop_r3");
    addVec(0, 3'b000, 8'h0F, "right_drop_r4");
    addVec(0, 3'b000, 8'h00, "right_drop_idle");
    addVec(0, 3'b110, 8'hFF, "both_haz");
    addVec(0, 3'b110, 8'h00, "both_off");
    addVec(0, 3'b110, 8'hFF, "both_haz2");
    addVec(0, 3'b110, 8'h00, "both_off2");
    addVec(0, 3'b000, 8'h00, "both_rel");
    addVec(0, 3'b001, 8'hFF, "sw0_haz");
    addVec(0, 3'b001, 8'h00, "sw0_off");
    addVec(0, 3'b001, 8'hFF, "sw0_haz2");
    addVec(0, 3'b111, 8'h00, "all_off");
    addVec(0, 3'b111, 8'hFF, "all_haz");
    addVec(0, 3'b101, 8'h00, "sw0r_off");
    addVec(0, 3'b101, 8'hFF, "sw0r_haz");
    addVec(0, 3'b000, 8'h00, "haz_rel");
    addVec(0, 3'b000, 8'h00, "haz_rel_hold");
    addVec(0, 3'b010, 8'h10, "pre_l1");
    addVec(0, 3'b010, 8'h30, "pre_l2");
    addVec(0, 3'b010, 8'h70, "pre_l3");
    addVec(0, 3'b011, 8'hFF, "pre_haz");
    addVec(0, 3'b011, 8'h00, "pre_off");
    addVec(0, 3'b011, 8'hFF, "pre_haz2");
    addVec(0, 3'b000, 8'h00, "pre_rel");
    addVec(0, 3'b000, 8'h00, "pre_rel_hold");
    addVec(0, 3'b010, 8'h10, "chg_l1");
    addVec(0, 3'b100, 8'h30, "chg_l2");
    addVec(0, 3'b100, 8'h70, "chg_l3");
    addVec(0, 3'b100, 8'hF0, "chg_l4");
    addVec(0, 3'b100, 8'h00, "chg_idle");
    addVec(0, 3'b100, 8'h08, "chg_r1");
    addVec(0, 3'b100, 8'h0C, "rst_r2");
    addVec(0, 3'b100, 8'h0E, "rst_r3");
    addVec(1, 3'b100, 8'h00, "rst_mid");
    addVec(0, 3'b000, 8'h00, "rst_after");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].sw);
      checkOutput(vecs[i].name, tlight, vecs[i].exp);
    end

    // Slow step rate: after reset release the first tick lands on the 4th edge,
    // then every pattern is held for exactly 4 edges.
    seq4[0] = 8'h00;
    seq4[1] = 8'h10;
    seq4[2] = 8'h30;
    seq4[3] = 8'h70;
    seq4[4] = 8'hF0;
    seq4[5] = 8'h00;
    @(negedge clk);
    rst4 = 1'b1;
    sw4 = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("div4_reset", tlight4, 8'h00);
    @(negedge clk);
    rst4 = 1'b0;
    sw4 = 3'b010;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("div4_step%0d", k), tlight4, seq4[(k + 1) / 4]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
